// File: rtl/vend_change_dispenser.sv
// Payout controller: takes one settled transaction, releases the product if it
// was paid for, then returns change one coin at a time using greedy denominations.
module vend_change_dispenser #(
  parameter int CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CREDIT_W-1:0] req_credit,
  input  logic [CREDIT_W-1:0] req_price,
  input  logic                req_cancel,
  input  logic [2:0]          hop_empty,
  output logic                coin_valid,
  output logic [1:0]          coin,
  input  logic                coin_ack,
  output logic                vend,
  output logic                done,
  output logic                short,
  output logic [CREDIT_W-1:0] owed
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_VEND = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] C_ONE  = 2'b00;
  localparam logic [1:0] C_TWO  = 2'b01;
  localparam logic [1:0] C_FIVE = 2'b10;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      C_FIVE:  coin_value = CREDIT_W'(5);
      C_TWO:   coin_value = CREDIT_W'(2);
      C_ONE:   coin_value = CREDIT_W'(1);
      default: coin_value = '0;
    endcase
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic                cancel_q, cancel_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic [1:0]          coin_q, coin_d;
  logic                short_q, short_d;
  logic [CREDIT_W-1:0] owed_q, owed_d;

  logic                purchase;
  logic [1:0]          pick_c;
  logic                pick_ok;

  assign purchase = !cancel_q && (credit_q >= price_q);

  // Greedy pick: largest denomination that is stocked and does not overpay.
  always_comb begin
    pick_c  = C_ONE;
    pick_ok = 1'b0;
    if (!hop_empty[2] && remaining_q >= coin_value(C_FIVE)) begin
      pick_c  = C_FIVE;
      pick_ok = 1'b1;
    end else if (!hop_empty[1] && remaining_q >= coin_value(C_TWO)) begin
      pick_c  = C_TWO;
      pick_ok = 1'b1;
    end else if (!hop_empty[0] && remaining_q >= coin_value(C_ONE)) begin
      pick_c  = C_ONE;
      pick_ok = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    price_d     = price_q;
    cancel_d    = cancel_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    short_d     = short_q;
    owed_d      = owed_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          credit_d = req_credit;
          price_d  = req_price;
          cancel_d = req_cancel;
          short_d  = 1'b0;
          owed_d   = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        remaining_d = purchase ? (credit_q - price_q) : credit_q;
        state_d     = purchase ? S_VEND : S_PAY;
      end
      S_VEND: state_d = S_PAY;
      S_PAY: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (pick_ok) begin
          coin_d  = pick_c;
          state_d = S_WAIT;
        end else begin
          // Hopper cannot make the remaining change; report the shortfall.
          short_d = 1'b1;
          owed_d  = remaining_q;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_q);
          state_d     = S_PAY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      price_q     <= '0;
      cancel_q    <= 1'b0;
      remaining_q <= '0;
      coin_q      <= C_ONE;
      short_q     <= 1'b0;
      owed_q      <= '0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      price_q     <= price_d;
      cancel_q    <= cancel_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      short_q     <= short_d;
      owed_q      <= owed_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign coin_valid = (state_q == S_WAIT);
  assign coin       = coin_q;
  assign vend       = (state_q == S_VEND);
  assign done       = (state_q == S_DONE);
  assign short      = short_q;
  assign owed       = owed_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser: hand-computed coin sequences,
// pulse timing, shortfall reporting and asynchronous abort.
module tb_vend_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_credit;
  logic [5:0] req_price;
  logic       req_cancel;
  logic [2:0] hop_empty;
  logic       coin_valid;
  logic [1:0] coin;
  logic       coin_ack;
  logic       vend;
  logic       done;
  logic       short;
  logic [5:0] owed;

  int total = 0;
  int bad   = 0;

  vend_change_dispenser #(.CREDIT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_credit(req_credit), .req_price(req_price), .req_cancel(req_cancel),
    .hop_empty(hop_empty),
    .coin_valid(coin_valid), .coin(coin), .coin_ack(coin_ack),
    .vend(vend), .done(done), .short(short), .owed(owed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE to the done pulse. Cycle index 0 is the
  // CALC cycle (sampled just after the transfer edge).
  task automatic run_txn(
    input  logic [5:0]  cr, input logic [5:0] pr, input logic cn,
    input  logic [2:0]  hop, input int dly, input bit hold,
    output int          o_vend, output int o_vcyc, output int o_n,
    output logic [15:0] o_coins, output int o_dcyc,
    output logic        o_short, output logic [5:0] o_owed,
    output int          o_rdy, output logic o_short0);
    int         wcnt;
    logic       prev_cv;
    logic [1:0] prev_coin;
    bit         fin;
    int         k;
    wcnt = 0; prev_cv = 1'b0; prev_coin = 2'b00; fin = 1'b0;
    o_vend = 0; o_vcyc = -1; o_n = 0; o_coins = '0; o_dcyc = -1;
    o_short = 1'bx; o_owed = 'x; o_rdy = 0;
    k = 0;
    while (!req_ready && k < 50) begin
      step();
      k++;
    end
    hop_empty  = hop;
    req_credit = cr;
    req_price  = pr;
    req_cancel = cn;
    req_valid  = 1'b1;
    coin_ack   = (dly == 0);
    step();
    if (!hold) req_valid = 1'b0;
    o_short0 = short;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (cyc > 0) step();
      if (vend) begin
        o_vend++;
        if (o_vend == 1) o_vcyc = cyc;
      end
      if (req_ready) o_rdy++;
      if (coin_valid) begin
        if (!prev_cv) begin
          o_n++;
          o_coins = {o_coins[13:0], coin};
          wcnt = 0;
        end else begin
          chk("coin_stable", {30'd0, coin}, {30'd0, prev_coin});
        end
        wcnt++;
      end
      prev_cv = coin_valid;
      prev_coin = coin;
      if (dly > 0) coin_ack = coin_valid && (wcnt >= dly);
      if (done) begin
        fin = 1'b1;
        o_dcyc = cyc;
        o_short = short;
        o_owed = owed;
        req_valid = 1'b0;
      end
    end
    coin_ack = 1'b0;
    if (!fin) chk("txn_timeout", 32'd1, 32'd0);
  endtask

  int          n_vend, vcyc, ncoin, dcyc, rdy;
  logic [15:0] coins;
  logic        sh, sh0;
  logic [5:0]  ow;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_credit = '0; req_price = '0;
    req_cancel = 1'b0; hop_empty = 3'b000; coin_ack = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_coin_valid", {31'd0, coin_valid}, 32'd0);
    chk("rst_coin", {30'd0, coin}, 32'd0);
    chk("rst_vend", {31'd0, vend}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_short", {31'd0, short}, 32'd0);
    chk("rst_owed", {26'd0, owed}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step();

    // 13 - 5 = 8 change: 5+2+1
    run_txn(6'd13, 6'd5, 1'b0, 3'b000, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t1_vend_cnt", n_vend, 1);
    chk("t1_vend_cyc", vcyc, 1);
    chk("t1_ncoin", ncoin, 3);
    chk("t1_coins", {16'd0, coins}, 32'b10_01_00);
    chk("t1_done_cyc", dcyc, 9);
    chk("t1_short", {31'd0, sh}, 32'd0);
    chk("t1_owed", {26'd0, ow}, 32'd0);

    // cancel refunds 7: 5+2
    run_txn(6'd7, 6'd5, 1'b1, 3'b000, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t2_vend_cnt", n_vend, 0);
    chk("t2_ncoin", ncoin, 2);
    chk("t2_coins", {16'd0, coins}, 32'b10_01);
    chk("t2_done_cyc", dcyc, 6);
    chk("t2_short", {31'd0, sh}, 32'd0);

    // insufficient credit refunds 3: 2+1
    run_txn(6'd3, 6'd5, 1'b0, 3'b000, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t3_vend_cnt", n_vend, 0);
    chk("t3_ncoin", ncoin, 2);
    chk("t3_coins", {16'd0, coins}, 32'b01_00);
    chk("t3_short", {31'd0, sh}, 32'd0);

    // five-tube empty: 8 paid as four 2-unit coins
    run_txn(6'd13, 6'd5, 1'b0, 3'b100, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t4_ncoin", ncoin, 4);
    chk("t4_coins", {16'd0, coins}, 32'b01_01_01_01);
    chk("t4_done_cyc", dcyc, 11);
    chk("t4_short", {31'd0, sh}, 32'd0);

    // all tubes empty: short with 4 owed
    run_txn(6'd9, 6'd5, 1'b0, 3'b111, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t5_vend_cnt", n_vend, 1);
    chk("t5_ncoin", ncoin, 0);
    chk("t5_done_cyc", dcyc, 3);
    chk("t5_short", {31'd0, sh}, 32'd1);
    chk("t5_owed", {26'd0, ow}, 32'd4);
    step();
    chk("t5_short_hold", {31'd0, short}, 32'd1);
    chk("t5_owed_hold", {26'd0, owed}, 32'd4);

    // exact price with req_valid held throughout; short cleared by transfer
    run_txn(6'd6, 6'd6, 1'b0, 3'b000, 0, 1'b1, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t6_short_clear", {31'd0, sh0}, 32'd0);
    chk("t6_vend_cnt", n_vend, 1);
    chk("t6_ncoin", ncoin, 0);
    chk("t6_done_cyc", dcyc, 3);
    chk("t6_ready_busy", rdy, 0);
    chk("t6_owed", {26'd0, ow}, 32'd0);
    step();
    chk("t6_ready_again", {31'd0, req_ready}, 32'd1);

    // slow hopper: 7 change as 5+2, three WAIT cycles per coin
    run_txn(6'd12, 6'd5, 1'b0, 3'b000, 3, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t7_ncoin", ncoin, 2);
    chk("t7_coins", {16'd0, coins}, 32'b10_01);
    chk("t7_done_cyc", dcyc, 11);

    // same transaction aborted by reset in the second WAIT
    step();
    begin
      int  n;
      int  wc;
      logic pcv;
      bit  hit;
      int  dcnt;
      n = 0; wc = 0; pcv = 1'b0; hit = 1'b0; dcnt = 0;
      req_credit = 6'd12; req_price = 6'd5; req_cancel = 1'b0; hop_empty = 3'b000;
      req_valid = 1'b1; coin_ack = 1'b0;
      step();
      req_valid = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        if (c > 0) step();
        if (coin_valid && !pcv) begin
          n++;
          wc = 0;
        end
        if (coin_valid) wc++;
        pcv = coin_valid;
        if (n == 2) hit = 1'b1;
        else coin_ack = coin_valid && (wc >= 3);
      end
      coin_ack = 1'b0;
      chk("t8_reached_wait2", {31'd0, hit}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t8_coin_valid", {31'd0, coin_valid}, 32'd0);
      chk("t8_ready", {31'd0, req_ready}, 32'd1);
      chk("t8_vend", {31'd0, vend}, 32'd0);
      @(negedge clk) rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (done) dcnt++;
      end
      chk("t8_no_done", dcnt, 0);
      chk("t8_ready_idle", {31'd0, req_ready}, 32'd1);
    end

    // fresh transaction after abort: 3 change as 2+1
    run_txn(6'd8, 6'd5, 1'b0, 3'b000, 0, 1'b0, n_vend, vcyc, ncoin, coins, dcyc, sh, ow, rdy, sh0);
    chk("t9_vend_cnt", n_vend, 1);
    chk("t9_coins", {16'd0, coins}, 32'b01_00);
    chk("t9_ncoin", ncoin, 2);
    chk("t9_done_cyc", dcyc, 7);
    chk("t9_short", {31'd0, sh}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Payout-side controller of the vending machine. It accepts one settled transaction from the coin-acceptance FSM: accumulated credit, item price, and a cancel flag. It releases the product when the purchase is valid, then returns change to the coin hopper one coin at a time using a greedy denomination choice and a valid/ack handshake. It sits between the coin-acceptance FSM and the hopper/product actuators.

## Interface
- CREDIT_W, 6, width of credit/price/owed values in units of 5c (coin codes: 2'b00=1 unit, 2'b01=2 units, 2'b10=5 units; 2'b11 unused)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  transaction offered
- req_ready  out  1  high only in IDLE; transfer on req_valid && req_ready
- req_credit  in  CREDIT_W  credit inserted, sampled at transfer
- req_price  in  CREDIT_W  item price, sampled at transfer
- req_cancel  in  1  1 = refund entire credit, no product
- hop_empty  in  3  bit i = hopper tube for coin code i empty; sampled in PAY only
- coin_valid  out  1  change coin requested
- coin  out  2  coin code, stable while coin_valid
- coin_ack  in  1  hopper dispensed the coin
- vend  out  1  one-cycle product-release pulse
- done  out  1  one-cycle transaction-complete pulse
- short  out  1  valid with done: change could not be fully paid
- owed  out  CREDIT_W  valid with done: units still unpaid (0 unless short)

## Operation
- States: IDLE, CALC, VEND, PAY, WAIT, DONE. Outputs are Moore-decoded from state/registers.
- IDLE: req_ready=1. On transfer, latch credit, price, cancel → CALC.
- CALC: purchase = !cancel && credit >= price. remaining <= purchase ? credit-price : credit. → VEND if purchase, else PAY.
- VEND: vend=1 → PAY.
- PAY: pick largest code c in {10,01,00} with !hop_empty[c] and value(c) <= remaining.
  - remaining==0 → DONE, short=0.
  - Eligible c found → coin<=c → WAIT.
  - None found (remaining>0) → DONE, short=1, owed=remaining.
- WAIT: coin_valid=1, coin held. On coin_ack: remaining -= value(coin) → PAY. Without ack, stay indefinitely.
- DONE: done=1 → IDLE. short/owed hold until the next transfer, then clear to 0.
- Arithmetic: subtraction is unsigned, CREDIT_W bits. The selection rule guarantees no underflow. Insufficient credit (credit<price, no cancel) is a full refund with vend never asserted.
- Ignored inputs:
  - coin_ack outside WAIT.
  - req_valid outside IDLE; req_* are not sampled.
  - hop_empty changes during WAIT; they affect only the next PAY.

## Timing
- Reset values: req_ready=1, coin_valid=0, coin=2'b00, vend=0, done=0, short=0, owed=0, state=IDLE.
- Reset mid-operation aborts immediately (asynchronous): coin_valid and vend drop in the same cycle, and no done is produced.
- Transfer edge = E0.
  - CALC during E0..E1.
  - Purchase: VEND E1..E2 (vend high exactly one cycle).
  - First PAY: E2..E3 for a purchase, E1..E2 otherwise.
- PAY always lasts one cycle. Each coin costs 1 PAY cycle + ≥1 WAIT cycle. With coin_ack held high, coins are issued every 2 cycles.
- Exact-price purchase: done high in cycle E3..E4; req_ready high again from E4.
- coin_ack sampled at the rising edge while in WAIT. An ack present in the first WAIT cycle completes the coin at that edge.

## Test plan
- credit=13, price=5, cancel=0, hop_empty=000, coin_ack tied 1:
  - vend one cycle after CALC.
  - Coins 10,01,00 (5+2+1).
  - done with short=0, owed=0.
- credit=7, cancel=1: vend never asserts; coins 10,01; done short=0.
- credit=3, price=5, cancel=0: vend never asserts; coins 01,00 (full refund); done short=0.
- credit=13, price=5, hop_empty=100: coins 01,01,01,01; done short=0.
- credit=9, price=5, hop_empty=111: no coin_valid; done short=1, owed=4.
- credit=12, price=5, ack delayed 3 cycles per coin: coin_valid/coin stable for all waits.
  - Issue rst during the second WAIT: coin_valid=0 at once, no done, req_ready=1.
  - A new transaction afterward completes normally.
- credit=price=6: vend, no coins, done 3 cycles after transfer edge.
- req_valid held during payout: no second transfer until IDLE.
